// File: rtl/lsu_ctrl_if.sv
// Bundle of core-request and data-memory signals for the load/store unit.
// The slave view is the controller; the master view drives requests and plays memory.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        done;
  logic        err;
  logic        busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, done, err, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, done, err, busy
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding word-aligned access, ack timeout,
// and load-data extraction/extension for writeback.

// One byte lane: its enable bit and replicated store byte for the request size.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic        be_o,
  output logic [7:0]  wbyte_o
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    be_o    = 1'b0;
    wbyte_o = 8'h00;
    case (size_i)
      2'b00: begin
        be_o    = (off_i == L);
        wbyte_o = wdata_i[7:0];
      end
      2'b01: begin
        be_o    = (off_i[1] == L[1]);
        wbyte_o = wdata_i[8*(LANE%2) +: 8];
      end
      default: begin
        be_o    = 1'b1;
        wbyte_o = wdata_i[8*LANE +: 8];
      end
    endcase
    if (!we_i) wbyte_o = 8'h00;
  end
endmodule

module lsu_ctrl #(
  parameter int TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst_n,
  lsu_ctrl_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } acc_t;

  state_t      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [NUM_LANES-1:0]             lane_be;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_wd;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane #(.LANE(g)) u_lane (
      .size_i  (bus.req_funct3[1:0]),
      .off_i   (bus.req_addr[1:0]),
      .we_i    (bus.req_we),
      .wdata_i (bus.req_wdata),
      .be_o    (lane_be[g]),
      .wbyte_o (lane_wd[g])
    );
  end

  logic f3_ok, misal, legal;

  always_comb begin
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_we;  // unsigned forms exist only for loads
      default:                f3_ok = 1'b0;
    endcase
    misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    legal = f3_ok && !misal;
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  always_comb begin
    ld_b = bus.mem_rdata[{acc_q.off, 3'b000} +: 8];
    ld_h = acc_q.off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (acc_q.funct3)
      3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_fmt = {24'h0, ld_b};
      3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_fmt = {16'h0, ld_h};
      default: ld_fmt = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            addr_d  = {bus.req_addr[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wd;
            we_d    = bus.req_we;
            acc_d   = '{we: bus.req_we, funct3: bus.req_funct3, off: bus.req_addr[1:0]};
            cnt_d   = 8'h00;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Ack is tested first so it wins over a timeout on the same edge.
        if (bus.mem_ack) begin
          if (!acc_q.we) ld_d = ld_fmt;
          done_d  = 1'b1;
          we_d    = 1'b0;
          state_d = IDLE;
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          we_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      ld_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_req   = (state_q == WAIT);
  assign bus.busy      = (state_q == WAIT);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ld_data   = ld_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit controller between the execute stage and data memory.
- Produces the `ld_data` word consumed by the writeback select.
- Accepts one load/store request at a time and builds word-aligned memory accesses with byte enables. It waits on a memory acknowledge with timeout, then formats load data (sign/zero extension) before presenting it to writeback.

Parameters:
- TIMEOUT, 15: max cycles in WAIT without `mem_ack` before aborting with error (range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bits used for B/H)
- mem_req  output  1  memory access request
- mem_we  output  1  memory write strobe
- mem_addr  output  32  word address, `{req_addr[31:2], 2'b00}`
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  memory completion, single-cycle pulse
- mem_rdata  input  32  read word, valid with `mem_ack`
- ld_data  output  32  formatted load result
- done  output  1  one-cycle pulse: access completed
- err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- busy  output  1  high in WAIT (core stall)

Behaviour:
- **Reset:** asynchronous, acts immediately including mid-access. All outputs go low/zero: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `ld_data`=0, `done`=0, `err`=0, `busy`=0. State goes to IDLE and the timeout counter to 0.
- **States:** IDLE, WAIT.
- **IDLE:**
  - `req_ready`=1.
  - On a clock edge with `req_valid`=1, check legality:
    - Illegal funct3 (011, 110, 111, or 1xx with `req_we`=1) -> error.
    - H/HU with `addr[0]`=1 -> error.
    - W with `addr[1:0]`≠0 -> error.
  - Error case: `err`=1 for the next cycle, no memory access, remain in IDLE.
  - Legal case: register `mem_addr`, `mem_be`, `mem_wdata`, `mem_we`, and latch funct3 and `addr[1:0]`. Set `mem_req`=1 and `busy`=1, clear the counter, go to WAIT.
- **Byte enables / store data:**
  - B: `mem_be` = 1 << `addr[1:0]`, `mem_wdata` = `{4{wdata[7:0]}}`.
  - H: `mem_be` = `addr[1]` ? 1100 : 0011, `mem_wdata` = `{2{wdata[15:0]}}`.
  - W: `mem_be` = 1111, `mem_wdata` = `wdata`.
  - Loads drive the same `be` pattern; `mem_wdata` = 0.
- **WAIT:**
  - `mem_req`, `mem_addr`, `mem_be`, `mem_we`, `mem_wdata` are held stable.
  - `req_valid` is ignored.
  - The counter increments each cycle without ack.
  - **On `mem_ack`:**
    - Load: `ld_data` is registered from `mem_rdata` by lane select on the latched `addr[1:0]`.
      - B: sign-extend byte.
      - BU: zero-extend byte.
      - H: sign-extend half.
      - HU: zero-extend half.
      - W: pass through.
    - Store: `ld_data` unchanged.
    - `done`=1 the cycle after ack; `mem_req`/`busy` drop the same cycle; go to IDLE.
  - **Timeout:** the counter reaches TIMEOUT with no ack -> `err`=1 next cycle, `mem_req` drops, go to IDLE, `ld_data` unchanged.
  - If ack arrives on the same edge the counter hits TIMEOUT, the ack wins.
- **Latency:** request accepted at edge N; `mem_req` high from N. If ack is sampled at edge N+k, `done` and new `ld_data` are visible after edge N+k, so minimum load latency is 2 cycles.
- **Back-to-back:** a new request may be accepted on the edge following the `done`/`err` cycle's entry to IDLE (`req_ready` high again).
- **Ignored inputs:** `mem_ack` in IDLE is ignored. `ld_data` holds its last load value indefinitely.
- `done` and `err` are never high together.

Test Plan:
- **LB sign:** load funct3=000, addr=0x1003, `mem_rdata`=0x80AA_BBCC, ack after 1 cycle -> `mem_addr`=0x1000, `mem_be`=1000, `ld_data`=0xFFFF_FF80, `done` single pulse.
- **LHU / LW:** LHU addr=0x2002, `mem_rdata`=0xBEEF_1234 -> `be`=1100, `ld_data`=0x0000_BEEF. LW addr=0x2000 -> `ld_data`=0xBEEF_1234.
- **Stores:** SB addr=0x11 `wdata`=0x0000_00AB -> `mem_we`=1, `be`=0010, `mem_wdata`=0xABAB_ABAB. SH addr=0x12 `wdata`=0x1234 -> `be`=1100, `mem_wdata`=0x1234_1234. `ld_data` keeps its prior value.
- **Misaligned/illegal:** LW addr=0x3001, SH addr=0x5, funct3=011 -> `err` pulse each, `mem_req` never asserted, `req_ready` stays 1.
- **Timeout:** TIMEOUT=15, load with no ack -> `busy` high 15 cycles, then `err`=1 one cycle, `mem_req`=0, IDLE. A repeat with ack on the 15th cycle -> `done`, no `err`.
- **Reset mid-WAIT:** drop `rst_n` asynchronously while `mem_req`=1 -> `mem_req`, `busy`, `ld_data` go 0 immediately. After release, a late `mem_ack` is ignored and a new LW completes normally.
